// File: rtl/fwft_fifo_mc_pkg.sv
// Shared types, defaults and helpers for the multi-channel FWFT FIFO.
// Build option FWFT_FIFO_PARITY_EN adds one even-parity bit to every stored entry.
package fwft_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned CH_NUM_DEF = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32;
  // Status struct count width; channels must be built with DEPTH_DEF for it to line up.
  localparam int unsigned ST_CNT_W   = clog2(DEPTH_DEF) + 1;

`ifdef FWFT_FIFO_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  localparam int unsigned ENTRY_W = DATA_W_DEF + PAR_W;

  typedef struct packed {
    logic                full;
    logic                afull;
    logic                empty;
    logic                aempty;
    logic [ST_CNT_W-1:0] cnt;
  } ch_status_t;

endpackage

// File: rtl/fwft_fifo_mc_if.sv
// Flattened per-channel handshake bus between a client (master) and the FIFO block (slave).
interface fwft_fifo_mc_if
  import fwft_fifo_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = ST_CNT_W
);
  logic [CH_NUM-1:0]        clr;
  logic [CH_NUM-1:0]        wen;
  logic [CH_NUM*DATA_W-1:0] wdata;
  logic [CH_NUM-1:0]        par_inj;
  logic [CH_NUM-1:0]        full;
  logic [CH_NUM-1:0]        afull;
  logic [CH_NUM-1:0]        ren;
  logic [CH_NUM*DATA_W-1:0] rdata;
  logic [CH_NUM-1:0]        empty;
  logic [CH_NUM-1:0]        aempty;
  logic [CH_NUM*CNT_W-1:0]  cnt;
  logic [CH_NUM-1:0]        overflow;
  logic [CH_NUM-1:0]        underflow;
  logic [CH_NUM-1:0]        err;

  modport master (
    output clr, wen, wdata, par_inj, ren,
    input  full, afull, rdata, empty, aempty, cnt, overflow, underflow, err
  );

  modport slave (
    input  clr, wen, wdata, par_inj, ren,
    output full, afull, rdata, empty, aempty, cnt, overflow, underflow, err
  );
endinterface

// File: rtl/fwft_fifo_mc_ch.sv
// One FWFT FIFO channel: flop-array storage, pointers, occupancy, registered flags, optional parity.
// Parity storage and checking exist only when FWFT_FIFO_PARITY_EN is defined.
module fwft_fifo_ch
  import fwft_fifo_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF,
  parameter int unsigned AFULL_THRESH  = DEPTH - 8,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              par_inj,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output ch_status_t        status,
  output logic              overflow,
  output logic              underflow,
  output logic              err
);
  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + PAR_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  wentry;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] rdata_d;
  ch_status_t        st_d;
  logic              wr_acc, rd_acc, ovf_d, und_d;

`ifdef FWFT_FIFO_PARITY_EN
  logic err_d;
  assign wentry = {(^wdata) ^ par_inj, wdata};
`else
  logic unused_par_inj;
  assign wentry         = wdata;
  assign unused_par_inj = par_inj;
`endif

  // Next-state: clr wins over both requests; flags follow the next count.
  always_comb begin
    wr_acc  = wen & ~status.full  & ~clr;
    rd_acc  = ren & ~status.empty & ~clr;
    ovf_d   = wen & status.full  & ~clr;
    und_d   = ren & status.empty & ~clr;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
      if (rd_acc) rptr_d = rptr_q + PTR_W'(1);
    end
    cnt_d       = clr ? '0 : status.cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    st_d.cnt    = cnt_d;
    st_d.full   = (cnt_d == CNT_W'(DEPTH));
    st_d.afull  = (cnt_d >= CNT_W'(AFULL_THRESH));
    st_d.empty  = (cnt_d == '0);
    st_d.aempty = (cnt_d <= CNT_W'(AEMPTY_THRESH));
    // Head slot may be the word being written this cycle (write into empty, or rd+wr at cnt=1).
    rdata_d = (wr_acc && (wptr_q == rptr_d)) ? wdata : mem[rptr_d][DATA_W-1:0];
`ifdef FWFT_FIFO_PARITY_EN
    err_d = clr ? 1'b0 : (err | (rd_acc & (^mem[rptr_q])));
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wentry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rdata     <= '0;
      status    <= '{full: 1'b0, afull: (AFULL_THRESH == 0), empty: 1'b1, aempty: 1'b1, cnt: '0};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rdata     <= rdata_d;
      status    <= st_d;
      overflow  <= ovf_d;
      underflow <= und_d;
    end
  end

`ifdef FWFT_FIFO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_d;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/fwft_fifo_mc.sv
// CH_NUM independent FWFT FIFOs sharing one clock; this level only slices the flattened bus.
// Optional parity protection is enabled by defining FWFT_FIFO_PARITY_EN.
module fwft_fifo_mc
  import fwft_fifo_pkg::*;
#(
  parameter int unsigned CH_NUM        = CH_NUM_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF,
  parameter int unsigned AFULL_THRESH  = DEPTH - 8,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fwft_fifo_mc_if.slave bus
);
  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  ch_status_t status [CH_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    fwft_fifo_ch #(
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH),
      .AEMPTY_THRESH(AEMPTY_THRESH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.clr[c]),
      .wen      (bus.wen[c]),
      .wdata    (bus.wdata[c*DATA_W +: DATA_W]),
      .par_inj  (bus.par_inj[c]),
      .ren      (bus.ren[c]),
      .rdata    (bus.rdata[c*DATA_W +: DATA_W]),
      .status   (status[c]),
      .overflow (bus.overflow[c]),
      .underflow(bus.underflow[c]),
      .err      (bus.err[c])
    );

    assign bus.full[c]                 = status[c].full;
    assign bus.afull[c]                = status[c].afull;
    assign bus.empty[c]                = status[c].empty;
    assign bus.aempty[c]               = status[c].aempty;
    assign bus.cnt[c*CNT_W +: CNT_W]   = status[c].cnt;
  end

endmodule

// File: tb/tb_fwft_fifo_mc.sv
// Directed bench for fwft_fifo_mc with a per-channel queue scoreboard and immediate assertions.
module tb_fwft_fifo_mc;
  import fwft_fifo_pkg::*;

  localparam int unsigned CH    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = 6;
  localparam int unsigned AFT   = DEPTH - 8;
  localparam int unsigned AET   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwft_fifo_mc_if #(.CH_NUM(CH), .DATA_W(DW), .CNT_W(CW)) bus ();

  fwft_fifo_mc #(
    .CH_NUM(CH), .DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW:0]   sb [CH][$];
  int            mcnt [CH];
  logic          e_ovf [CH];
  logic          e_und [CH];
  logic          e_err [CH];
  logic [DW-1:0] wd [CH];

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s ch%0d: observed %0h expected %0h", tag, c, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sb[c].delete();
      mcnt[c]  = 0;
      e_ovf[c] = 1'b0;
      e_und[c] = 1'b0;
      e_err[c] = 1'b0;
    end
  endtask

  task automatic inputs_idle();
    bus.clr = '0; bus.wen = '0; bus.ren = '0; bus.par_inj = '0; bus.wdata = '0;
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      chk("cnt",       c, 64'(bus.cnt[c*CW +: CW]), 64'(mcnt[c]));
      chk("empty",     c, 64'(bus.empty[c]),     64'(mcnt[c] == 0));
      chk("full",      c, 64'(bus.full[c]),      64'(mcnt[c] == DEPTH));
      chk("afull",     c, 64'(bus.afull[c]),     64'(mcnt[c] >= AFT));
      chk("aempty",    c, 64'(bus.aempty[c]),    64'(mcnt[c] <= AET));
      chk("overflow",  c, 64'(bus.overflow[c]),  64'(e_ovf[c]));
      chk("underflow", c, 64'(bus.underflow[c]), 64'(e_und[c]));
      chk("err",       c, 64'(bus.err[c]),       64'(e_err[c]));
      if (mcnt[c] > 0) chk("rdata", c, 64'(bus.rdata[c*DW +: DW]), 64'(sb[c][0][DW-1:0]));
    end
  endtask

  task automatic chk_reset();
    for (int c = 0; c < CH; c++) begin
      chk("rst_cnt",    c, 64'(bus.cnt[c*CW +: CW]), 64'(0));
      chk("rst_empty",  c, 64'(bus.empty[c]),     64'(1));
      chk("rst_aempty", c, 64'(bus.aempty[c]),    64'(1));
      chk("rst_full",   c, 64'(bus.full[c]),      64'(0));
      chk("rst_afull",  c, 64'(bus.afull[c]),     64'(0));
      chk("rst_ovf",    c, 64'(bus.overflow[c]),  64'(0));
      chk("rst_und",    c, 64'(bus.underflow[c]), 64'(0));
      chk("rst_err",    c, 64'(bus.err[c]),       64'(0));
      chk("rst_rdata",  c, 64'(bus.rdata[c*DW +: DW]), 64'(0));
    end
  endtask

  // One clock of stimulus: predict with the queue model, clock, then compare everything.
  task automatic drive(input logic [CH-1:0] clr_v, input logic [CH-1:0] wen_v,
                       input logic [CH-1:0] ren_v, input logic [CH-1:0] inj_v);
    logic       full_b, empty_b, wr, rd;
    logic [DW:0] head;
    bus.clr = clr_v; bus.wen = wen_v; bus.ren = ren_v; bus.par_inj = inj_v;
    for (int c = 0; c < CH; c++) bus.wdata[c*DW +: DW] = wd[c];
    for (int c = 0; c < CH; c++) begin
      full_b  = (mcnt[c] == DEPTH);
      empty_b = (mcnt[c] == 0);
      if (clr_v[c]) begin
        sb[c].delete();
        mcnt[c] = 0; e_ovf[c] = 1'b0; e_und[c] = 1'b0; e_err[c] = 1'b0;
      end else begin
        wr = wen_v[c] & ~full_b;
        rd = ren_v[c] & ~empty_b;
        e_ovf[c] = wen_v[c] & full_b;
        e_und[c] = ren_v[c] & empty_b;
        if (rd) begin
          head = sb[c].pop_front();
`ifdef FWFT_FIFO_PARITY_EN
          if (head[DW]) e_err[c] = 1'b1;
`endif
        end
        if (wr) sb[c].push_back({inj_v[c], wd[c]});
        mcnt[c] = mcnt[c] + int'(wr) - int'(rd);
      end
    end
    @(posedge clk);
    #1;
    inputs_idle();
    check_all();
  endtask

  initial begin
    inputs_idle();
    for (int c = 0; c < CH; c++) wd[c] = '0;
    model_reset();
    #2 rst = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_all();

    // Fill ch0 to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) begin
      wd[0] = DW'(i);
      drive(4'b0000, 4'b0001, 4'b0000, 4'b0000);
    end
    wd[0] = 32'hDEAD_0000;
    drive(4'b0000, 4'b0001, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // At full: simultaneous wen+ren rejects the write and pops one.
    wd[0] = 32'hDEAD_0001;
    drive(4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // Drain ch0 and pop once more for underflow.
    for (int i = 0; i < DEPTH; i++) drive(4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // At empty: simultaneous wen+ren, read rejected, word visible next cycle.
    wd[0] = 32'h0BAD_F00D;
    drive(4'b0000, 4'b0001, 4'b0001, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0001, 4'b0000);

    // Single word latency on ch1.
    wd[1] = 32'hA5A5_A5A5;
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0010, 4'b0000);

    // Steady state rd+wr at cnt=5 on ch1.
    for (int i = 0; i < 5; i++) begin
      wd[1] = 32'h1100_0000 + DW'(i);
      drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 8; i++) begin
      wd[1] = 32'h2200_0000 + DW'(i);
      drive(4'b0000, 4'b0010, 4'b0010, 4'b0000);
    end
    for (int i = 0; i < 5; i++) drive(4'b0000, 4'b0000, 4'b0010, 4'b0000);

    // Random 50% write/read traffic on ch2 across several pointer wraps.
    for (int i = 0; i < 200; i++) begin
      wd[2] = $urandom;
      drive(4'b0000, {1'b0, 1'(($urandom_range(0, 1))), 2'b00},
            {1'b0, 1'(($urandom_range(0, 1))), 2'b00}, 4'b0000);
    end
    while (mcnt[2] > 0) drive(4'b0000, 4'b0000, 4'b0100, 4'b0000);

    // clr on ch3 at cnt=10 wins over wen and ren.
    for (int i = 0; i < 10; i++) begin
      wd[3] = 32'h3300_0000 + DW'(i);
      drive(4'b0000, 4'b1000, 4'b0000, 4'b0000);
    end
    wd[3] = 32'h3333_3333;
    drive(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Parity injection on ch1; err expected only in the parity build, sticky until clr.
    wd[1] = 32'h0000_1234;
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0010);
    wd[1] = 32'h0000_0055;
    drive(4'b0000, 4'b0010, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Reset asserted mid-burst: outputs must drop without a clock edge.
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < CH; c++) wd[c] = $urandom;
      drive(4'b0000, 4'b1111, 4'b0000, 4'b0000);
    end
    bus.wen = 4'b1111;
    bus.ren = 4'b0101;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk_reset();
    inputs_idle();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_all();
    wd[0] = 32'hCAFE_0001;
    drive(4'b0000, 4'b0001, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0001, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
